systolic_input_feeder: RTL
==========================

# systolic_input_feeder

Streams a block of matrix rows from the on-chip input buffer into the systolic input skew stage, one word per cycle. It generates buffer read addresses, absorbs the buffer's 1-cycle read latency, holds data under downstream stall, and appends zero flush words so the last row fully drains through the skew shift registers. It sits directly upstream of the skew stage and drives that stage's word and enable inputs.

## Interface
- DATA_WIDTH, 8, bits per lane element
- LANES, 10, lanes per word; the word is LANES*DATA_WIDTH bits
- ADDR_WIDTH, 8, input buffer address width
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  start pulse; sampled only in IDLE
- base_addr_i  in  ADDR_WIDTH  first row address; captured on accepted start
- num_rows_i  in  ADDR_WIDTH  rows to feed; captured on accepted start
- stall_i  in  1  downstream hold; while high, no word is consumed
- rd_en_o  out  1  buffer read request
- rd_addr_o  out  ADDR_WIDTH  buffer read address
- rd_data_i  in  LANES*DATA_WIDTH  buffer data; valid exactly 1 cycle after rd_en_o
- word_o  out  LANES*DATA_WIDTH  word to the skew stage
- en_o  out  1  skew-stage enable; word_o is consumed when en_o=1
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  single-cycle completion pulse

## Operation
- States: IDLE, FEED, FLUSH, DONE.
- IDLE: start_i=1 captures base/num_rows. If num_rows=0, the next state is DONE. Otherwise the next state is FEED. start_i is ignored in every other state.
- FEED:
  - Issue rd_en_o with rd_addr_o = base + k for k = 0..num_rows-1.
  - Read data lands in the output register. If the output register is occupied and stalled, data lands in a 1-entry skid register instead.
  - rd_en_o=0 when stall_i=1 or the skid register is full.
  - Address arithmetic is modulo 2^ADDR_WIDTH; 0xFF+1 wraps to 0x00.
- After the last row is consumed, the next state is FLUSH.
- FLUSH: emit LANES-1 all-zero words, each with en_o=1, subject to stall_i. Then the next state is DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- en_o = output_valid & ~stall_i. word_o holds its value while stalled. word_o is zero whenever output_valid=0.
- Rows are emitted in address order. None are dropped or duplicated under any stall pattern.

## Timing
- Reset values: rd_en_o=0, rd_addr_o=0, word_o=0, en_o=0, busy_o=0, done_o=0; state IDLE; skid empty.
- Start accepted at cycle T, no stall:
  - rd_en_o=1 at T+1.
  - First en_o/word_o at T+2.
  - Rows are back-to-back, one per cycle.
  - Last row at T+1+num_rows.
  - Flush words follow immediately.
  - done_o at T+2+num_rows+(LANES-1).
- num_rows=0: done_o at T+1, no en_o, no rd_en_o.
- Stall asserted for S cycles: completion slips by exactly S cycles. The read returning during the first stall cycle is held in the skid register.
- Stall and read-data arrival in the same cycle: data goes to skid; rd_en_o is deasserted from the same cycle.
- Stall during FLUSH: the zero word holds and the flush counter does not advance.
- rst_ni low at any point, including mid-FEED or mid-FLUSH: all outputs return to reset values immediately (asynchronously). In-flight reads are discarded. No done_o is produced for the aborted job.

## Configuration
- SYSTOLIC_FEEDER_FLUSH_EN defined: the FLUSH state is present and LANES-1 zero words follow the last row.
- SYSTOLIC_FEEDER_FLUSH_EN undefined: FEED goes directly to DONE after the last row is consumed, and done_o fires one cycle after it. Back-to-back jobs then fill the skew pipeline without bubbles; the controller is responsible for draining.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles; start_i=0 -> busy_o stays 0.
- base=0x10, num_rows=3, rows A/B/C, no stall, flush on:
  - rd_addr_o 0x10,0x11,0x12 at T+1..T+3
  - en_o words A,B,C at T+2..T+4
  - 9 zero words at T+5..T+13
  - done_o at T+14
- Same job with stall_i=1 for 2 cycles at T+3: words A,B,C in order, none duplicated; done_o at T+16.
- base=0xFE, num_rows=3: rd_addr_o sequence 0xFE,0xFF,0x00.
- num_rows=0: done_o at T+1, en_o and rd_en_o never asserted; start_i while busy on a 4-row job is ignored.
- rst_ni pulsed low at T+4 of a 5-row job: outputs 0 immediately; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/systolic_input_feeder.sv
// Streams a block of matrix rows from the input buffer into the systolic skew stage.
// Build option: define SYSTOLIC_FEEDER_FLUSH_EN to append LANES-1 zero words after the last row.

module systolic_input_feeder_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_cap,
  input  logic                  i_sel_skid,
  input  logic                  i_sel_rd,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_word
);
  logic [DATA_WIDTH-1:0] r_skid;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)    r_skid <= '0;
    else if (i_cap) r_skid <= i_rd_data;

  always_comb begin
    o_word = '0;
    if (i_sel_skid)    o_word = r_skid;
    else if (i_sel_rd) o_word = i_rd_data;
  end
endmodule

module systolic_input_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 10,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [ADDR_WIDTH-1:0]       base_addr_i,
  input  logic [ADDR_WIDTH-1:0]       num_rows_i,
  input  logic                        stall_i,
  output logic                        rd_en_o,
  output logic [ADDR_WIDTH-1:0]       rd_addr_o,
  input  logic [LANES*DATA_WIDTH-1:0] rd_data_i,
  output logic [LANES*DATA_WIDTH-1:0] word_o,
  output logic                        en_o,
  output logic                        busy_o,
  output logic                        done_o
);
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
  localparam int FLUSH_WORDS = LANES - 1;
`else
  localparam int FLUSH_WORDS = 0;
`endif
  localparam int FCW = $clog2(LANES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
  } rd_req_t;

  logic [1:0]            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, r_to_issue, r_to_consume;
  logic [FCW-1:0]        r_flush_cnt;
  logic                  r_rd_pend, r_skid_vld;
  logic                  w_start, w_out_vld, w_en, w_skid_cap, w_skid_hold;
  logic                  w_last_row, w_flush_last;
  rd_req_t               w_req;
  logic [LANES-1:0][DATA_WIDTH-1:0] w_rd_data, w_word;

  assign w_start    = (r_state == S_IDLE) & start_i;
  assign w_out_vld  = r_skid_vld | r_rd_pend | (r_state == S_FLUSH);
  assign w_en       = w_out_vld & ~stall_i;
  // Returning data that cannot be consumed this cycle parks in the skid.
  assign w_skid_cap  = r_rd_pend & stall_i & ~r_skid_vld;
  // A skid draining this cycle is free again by the time a new read returns.
  assign w_skid_hold = r_skid_vld & ~w_en;

  assign w_req.en   = (r_state == S_FEED) & (r_to_issue != '0) & ~stall_i & ~w_skid_hold;
  assign w_req.addr = r_addr;

  assign w_last_row   = (r_state == S_FEED) & w_en & (r_to_consume == ADDR_WIDTH'(1));
  assign w_flush_last = (r_state == S_FLUSH) & w_en & (r_flush_cnt == FCW'(FLUSH_WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = (num_rows_i == '0) ? S_DONE : S_FEED;
      S_FEED:  if (w_last_row) w_state_nxt = (FLUSH_WORDS == 0) ? S_DONE : S_FLUSH;
      S_FLUSH: if (w_flush_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_to_issue   <= '0;
      r_to_consume <= '0;
      r_flush_cnt  <= '0;
      r_rd_pend    <= 1'b0;
      r_skid_vld   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_req.en;
      if (w_skid_cap)                r_skid_vld <= 1'b1;
      else if (r_skid_vld && w_en)   r_skid_vld <= 1'b0;
      if (w_start) begin
        r_addr       <= base_addr_i;
        r_to_issue   <= num_rows_i;
        r_to_consume <= num_rows_i;
        r_flush_cnt  <= '0;
      end else begin
        if (w_req.en) begin
          r_addr     <= r_addr + ADDR_WIDTH'(1);
          r_to_issue <= r_to_issue - ADDR_WIDTH'(1);
        end
        if (r_state == S_FEED && w_en)  r_to_consume <= r_to_consume - ADDR_WIDTH'(1);
        if (r_state == S_FLUSH && w_en) r_flush_cnt  <= r_flush_cnt + FCW'(1);
      end
    end
  end

  assign w_rd_data = rd_data_i;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    systolic_input_feeder_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_cap      (w_skid_cap),
      .i_sel_skid (r_skid_vld),
      .i_sel_rd   (r_rd_pend),
      .i_rd_data  (w_rd_data[i]),
      .o_word     (w_word[i])
    );
  end

  assign rd_en_o   = w_req.en;
  assign rd_addr_o = w_req.addr;
  assign word_o    = w_word;
  assign en_o      = w_en;
  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = (r_state == S_DONE);
endmodule
